// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline register stage with stall/bubble/flush control
// and saturating stall/bubble performance counters. All outputs are registered.
module pipe_stage_reg #(
    parameter int unsigned          PAYLOAD_W   = 81,
    parameter int unsigned          STALL_W     = 6,
    parameter int unsigned          STAGE       = 2,
    parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0,
    parameter int unsigned          CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 in_is_in_delayslot,
    input  logic                 in_next_in_delayslot,
    input  logic                 cnt_clr,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_is_in_delayslot,
    output logic                 out_next_in_delayslot,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    localparam int unsigned      UP_IDX  = STAGE;
    localparam int unsigned      DN_IDX  = STAGE + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ACT_CAPTURE = 2'd0,
        ACT_HOLD    = 2'd1,
        ACT_BUBBLE  = 2'd2,
        ACT_FLUSH   = 2'd3
    } act_e;

    act_e act_c;
    logic stall_inc_c;
    logic bubble_inc_c;
    logic stall_unused;

    // Only the two stall bits around this stage matter; the rest are ignored.
    assign stall_unused = ^stall;

    // Choose this cycle's action: flush > bubble > hold > capture.
    always_comb begin
        act_c        = ACT_CAPTURE;
        stall_inc_c  = 1'b0;
        bubble_inc_c = 1'b0;
        if (flush) begin
            act_c = ACT_FLUSH;
        end else if (stall[UP_IDX]) begin
            stall_inc_c = 1'b1;
            if (stall[DN_IDX]) begin
                act_c = ACT_HOLD;
            end else begin
                act_c        = ACT_BUBBLE;
                bubble_inc_c = 1'b1;
            end
        end
    end

    // Stage register; a bubble keeps the branch loop-back flag so the
    // delay slot is still recognised when upstream resumes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid             <= 1'b0;
            out_payload           <= NOP_PAYLOAD;
            out_is_in_delayslot   <= 1'b0;
            out_next_in_delayslot <= 1'b0;
        end else begin
            case (act_c)
                ACT_FLUSH: begin
                    out_valid             <= 1'b0;
                    out_payload           <= NOP_PAYLOAD;
                    out_is_in_delayslot   <= 1'b0;
                    out_next_in_delayslot <= 1'b0;
                end
                ACT_BUBBLE: begin
                    out_valid           <= 1'b0;
                    out_payload         <= NOP_PAYLOAD;
                    out_is_in_delayslot <= 1'b0;
                end
                ACT_HOLD: begin
                end
                default: begin
                    out_valid             <= in_valid;
                    out_payload           <= in_payload;
                    out_is_in_delayslot   <= in_is_in_delayslot;
                    out_next_in_delayslot <= in_next_in_delayslot;
                end
            endcase
        end
    end

    // Saturating performance counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall_inc_c && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (bubble_inc_c && (bubble_cnt != CNT_MAX)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench; a default-width instance and a 2-bit
// counter instance share stimulus, expected results come from a priority model.
module tb_pipe_stage_reg;

    localparam int unsigned PW = 81;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    stall = '0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_payload = '0;
    logic          in_ids = 1'b0;
    logic          in_nds = 1'b0;
    logic          cnt_clr = 1'b0;

    logic          a_valid, b_valid;
    logic [PW-1:0] a_payload, b_payload;
    logic          a_ids, b_ids, a_nds, b_nds;
    logic [15:0]   a_sc, a_bc;
    logic [1:0]    b_sc, b_bc;

    always #5 clk = ~clk;

    pipe_stage_reg dut_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_payload(in_payload),
        .in_is_in_delayslot(in_ids), .in_next_in_delayslot(in_nds),
        .cnt_clr(cnt_clr),
        .out_valid(a_valid), .out_payload(a_payload),
        .out_is_in_delayslot(a_ids), .out_next_in_delayslot(a_nds),
        .stall_cnt(a_sc), .bubble_cnt(a_bc)
    );

    pipe_stage_reg #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_payload(in_payload),
        .in_is_in_delayslot(in_ids), .in_next_in_delayslot(in_nds),
        .cnt_clr(cnt_clr),
        .out_valid(b_valid), .out_payload(b_payload),
        .out_is_in_delayslot(b_ids), .out_next_in_delayslot(b_nds),
        .stall_cnt(b_sc), .bubble_cnt(b_bc)
    );

    typedef struct {
        string         name;
        logic          v;
        logic [PW-1:0] p;
        logic          ids;
        logic          nds;
        logic [15:0]   sc;
        logic [15:0]   bc;
        logic [1:0]    sc2;
        logic [1:0]    bc2;
    } exp_t;

    exp_t exp_q[$];

    // Reference state
    logic          m_v = 1'b0;
    logic [PW-1:0] m_p = '0;
    logic          m_ids = 1'b0, m_nds = 1'b0;
    logic [15:0]   m_sc = '0, m_bc = '0;
    logic [1:0]    m_sc2 = '0, m_bc2 = '0;

    int n_total = 0;
    int n_pass  = 0;

    // Single comparison point for every check.
    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Drive one cycle, advance the model and push its expectation; after the
    // edge pop the expectation and compare both instances.
    task automatic step(input string name, input logic r, input logic [5:0] st, input logic fl,
                        input logic v, input logic [PW-1:0] p, input logic ids,
                        input logic nds, input logic clr);
        exp_t e;
        logic up, dn;
        rst = r; stall = st; flush = fl; in_valid = v; in_payload = p;
        in_ids = ids; in_nds = nds; cnt_clr = clr;
        up = st[2];
        dn = st[3];
        if (r) begin
            m_v = 0; m_p = '0; m_ids = 0; m_nds = 0;
        end else if (fl) begin
            m_v = 0; m_p = '0; m_ids = 0; m_nds = 0;
        end else if (up && !dn) begin
            m_v = 0; m_p = '0; m_ids = 0;
        end else if (!up) begin
            m_v = v; m_p = p; m_ids = ids; m_nds = nds;
        end
        if (r || clr) begin
            m_sc = '0; m_bc = '0; m_sc2 = '0; m_bc2 = '0;
        end else if (!fl && up) begin
            if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
            if (m_sc2 != 2'd3) m_sc2 = m_sc2 + 2'd1;
            if (!dn) begin
                if (m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
                if (m_bc2 != 2'd3) m_bc2 = m_bc2 + 2'd1;
            end
        end
        e.name = name; e.v = m_v; e.p = m_p; e.ids = m_ids; e.nds = m_nds;
        e.sc = m_sc; e.bc = m_bc; e.sc2 = m_sc2; e.bc2 = m_bc2;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq({e.name, ".valid"},   128'(a_valid),   128'(e.v));
        check_eq({e.name, ".payload"}, 128'(a_payload), 128'(e.p));
        check_eq({e.name, ".ids"},     128'(a_ids),     128'(e.ids));
        check_eq({e.name, ".nds"},     128'(a_nds),     128'(e.nds));
        check_eq({e.name, ".stall_cnt"},  128'(a_sc),   128'(e.sc));
        check_eq({e.name, ".bubble_cnt"}, 128'(a_bc),   128'(e.bc));
        check_eq({e.name, ".b_payload"},  128'(b_payload), 128'(e.p));
        check_eq({e.name, ".b_valid_nds"}, 128'({b_valid, b_ids, b_nds}),
                 128'({e.v, e.ids, e.nds}));
        check_eq({e.name, ".stall_cnt2"},  128'(b_sc),  128'(e.sc2));
        check_eq({e.name, ".bubble_cnt2"}, 128'(b_bc),  128'(e.bc2));
    endtask

    logic [PW-1:0] pa, pb;

    initial begin
        pa = PW'(81'h1_2345_6789_ABCD_EF01_2345);
        pb = PW'(81'h0_BEEF_0000_1111_2222_3333);
        @(posedge clk);
        #1;
        // Reset then capture
        step("reset",    1, 6'b000000, 0, 1, pa, 1, 1, 0);
        step("cap",      0, 6'b000000, 0, 1, PW'(20'h1_2345), 0, 0, 0);
        // Bubble then resume with B
        step("cap_a",    0, 6'b000000, 0, 1, pa, 0, 0, 0);
        step("bubble",   0, 6'b000100, 0, 1, pb, 1, 1, 0);
        step("resume_b", 0, 6'b000000, 0, 1, pb, 0, 0, 0);
        // Hold three cycles
        step("clr",      0, 6'b000000, 0, 1, pa, 1, 0, 1);
        step("hold1",    0, 6'b001100, 0, 1, pb, 0, 1, 0);
        step("hold2",    0, 6'b001100, 0, 0, pb, 0, 1, 0);
        step("hold3",    0, 6'b001100, 0, 1, pb, 0, 1, 0);
        // Flush beats stall; counters untouched
        step("cap_nds",  0, 6'b000000, 0, 1, pa, 1, 1, 0);
        step("flush",    0, 6'b000100, 1, 1, pb, 1, 1, 0);
        // Delay-slot flag survives a bubble
        step("ds_cap",   0, 6'b000000, 0, 1, pa, 0, 1, 0);
        step("ds_bub1",  0, 6'b000100, 0, 1, pb, 1, 0, 0);
        step("ds_bub2",  0, 6'b000100, 0, 1, pb, 1, 0, 0);
        step("ds_clear", 0, 6'b000000, 0, 1, pb, 1, 0, 0);
        // Unrelated stall bits ignored
        step("other_st", 0, 6'b110011, 0, 1, pa, 0, 1, 0);
        step("other_st2",0, 6'b110011, 0, 0, pb, 1, 0, 0);
        // Invalid capture keeps payload
        step("inv_cap",  0, 6'b000000, 0, 0, pa, 0, 0, 0);
        // Reset mid-hold, then normal capture
        step("mh_hold",  0, 6'b001100, 0, 1, pb, 0, 0, 0);
        step("mh_rst",   1, 6'b001100, 1, 1, pb, 1, 1, 1);
        step("mh_cap",   0, 6'b000000, 0, 1, pb, 1, 0, 0);
        // Saturation of 2-bit counter, then clear during stall
        for (int i = 0; i < 5; i++) step("sat_hold", 0, 6'b001100, 0, 1, pa, 0, 0, 0);
        step("sat_clr",  0, 6'b001100, 0, 1, pa, 0, 0, 1);
        step("sat_bub",  0, 6'b000100, 0, 1, pa, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("bub_sat", 0, 6'b000100, 0, 1, pa, 0, 0, 0);
        // Random mix
        for (int i = 0; i < 60; i++) begin
            step("rand", ($urandom_range(0, 15) == 0), 6'($urandom), ($urandom_range(0, 7) == 0),
                 1'($urandom), PW'({$urandom, $urandom, $urandom}), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 15) == 0));
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter PAYLOAD_W, default 81, payload width in bits (aluop, alusel, reg1, reg2, wd, wreg packed).
REQ-002 Parameter STALL_W, default 6, width of the stall vector.
REQ-003 Parameter STAGE, default 2, upstream index into stall; the downstream index is STAGE+1; legal range 0..STALL_W-2.
REQ-004 Parameter NOP_PAYLOAD, default all-zero PAYLOAD_W-bit value, payload driven for a bubble.
REQ-005 Parameter CNT_W, default 16, width of the performance counters.
REQ-006 clk  in  1  single clock, all state updates on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 stall  in  STALL_W  per-stage stall vector, 1 = Stop.
REQ-009 flush  in  1  exception flush, kills stage contents.
REQ-010 in_valid  in  1  upstream holds a real instruction.
REQ-011 in_payload  in  PAYLOAD_W  upstream decoded fields.
REQ-012 in_is_in_delayslot  in  1  upstream instruction sits in a delay slot.
REQ-013 in_next_in_delayslot  in  1  upstream instruction is a branch, so its successor is a delay slot.
REQ-014 cnt_clr  in  1  synchronous clear of both counters.
REQ-015 out_valid  out  1  registered valid toward downstream.
REQ-016 out_payload  out  PAYLOAD_W  registered payload.
REQ-017 out_is_in_delayslot  out  1  registered delay-slot flag.
REQ-018 out_next_in_delayslot  out  1  registered loop-back to upstream decode.
REQ-019 stall_cnt  out  CNT_W  saturating count of cycles with stall[STAGE]=1.
REQ-020 bubble_cnt  out  CNT_W  saturating count of bubble insertions.

Function
REQ-021 Per-cycle action SHALL be chosen by strict priority: rst > flush > bubble > hold > capture.
REQ-022 Flush (flush=1) SHALL load out_valid=0, out_payload=NOP_PAYLOAD, out_is_in_delayslot=0, out_next_in_delayslot=0, regardless of stall.
REQ-023 Bubble (stall[STAGE]=1, stall[STAGE+1]=0) SHALL load out_valid=0, out_payload=NOP_PAYLOAD, out_is_in_delayslot=0, and hold out_next_in_delayslot.
REQ-024 Hold (stall[STAGE]=1, stall[STAGE+1]=1) SHALL keep all four registered outputs unchanged.
REQ-025 Capture (stall[STAGE]=0) SHALL load out_valid=in_valid, out_payload=in_payload, out_is_in_delayslot=in_is_in_delayslot, out_next_in_delayslot=in_next_in_delayslot.
REQ-026 Capture with in_valid=0 SHALL still load in_payload unmodified; downstream qualifies on out_valid.
REQ-027 Latency SHALL be exactly one cycle from input to output on capture; no combinational path SHALL exist from any input to any output.
REQ-028 Stall bits other than STAGE and STAGE+1 SHALL have no effect.
REQ-029 stall_cnt SHALL increment by 1 in every cycle with stall[STAGE]=1 and flush=0, and SHALL saturate at 2^CNT_W-1.
REQ-030 bubble_cnt SHALL increment by 1 in every bubble cycle (REQ-023) and SHALL saturate at 2^CNT_W-1.
REQ-031 cnt_clr=1 SHALL zero both counters on the next edge, overriding a same-cycle increment.
REQ-032 flush SHALL NOT clear the counters; a flush cycle SHALL count as neither a stall nor a bubble.

Reset
REQ-033 With rst=1 at an edge, out_valid=0, out_payload=NOP_PAYLOAD, out_is_in_delayslot=0, out_next_in_delayslot=0, stall_cnt=0, bubble_cnt=0, overriding flush, stall and cnt_clr.
REQ-034 Reset asserted mid-hold SHALL discard the held contents; the first edge after rst deasserts with stall=0 SHALL capture normally.

Verification
REQ-035 Reset then capture: rst=1 one cycle, then stall=0, in_valid=1, in_payload=0x1_2345 -> after one edge out_valid=1, out_payload=0x1_2345, counters 0.
REQ-036 Bubble: stall=6'b000100 with payload A loaded -> out_valid=0, out_payload=0, bubble_cnt=1, stall_cnt=1; then stall=0 with in_payload=B -> out_payload=B next cycle.
REQ-037 Hold: stall=6'b001100 for 3 cycles with payload A loaded -> out_payload=A throughout, stall_cnt=3, bubble_cnt=0.
REQ-038 Flush priority: flush=1 and stall=6'b000100 together -> NOP outputs, out_next_in_delayslot=0, stall_cnt and bubble_cnt unchanged.
REQ-039 Delay slot: capture with in_next_in_delayslot=1, then bubble -> out_next_in_delayslot stays 1 during the bubble and clears only on the next capture with in_next_in_delayslot=0.
REQ-040 Saturation/clear: CNT_W=2, hold for 5 cycles -> stall_cnt=3; cnt_clr=1 with stall still active -> stall_cnt=0 next cycle.
